dice_sampler: RTL and testbench
===============================

DICE_SAMPLER -- requirements
Module: dice_sampler

Interface
REQ-001 Parameter: STEPS, default 3, number of generator advance pulses issued before each sample (1..7).
REQ-002 Parameter: MAX_TRY, default 15, maximum rejected samples per die before fallback (1..15).
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 roll_req  input  1  request one roll of two dice; sampled only in IDLE.
REQ-006 rnd  input  6  current word of the external 6-bit shift-register generator; only rnd[2:0] is used.
REQ-007 adv  output  1  generator advance enable; the generator shifts on every rising edge where adv=1, and the new rnd is visible in the following cycle.
REQ-008 die1  output  3  first die value, 1..6 once valid.
REQ-009 die2  output  3  second die value, 1..6 once valid.
REQ-010 sum  output  4  die1+die2, range 2..12.
REQ-011 valid  output  1  one-cycle pulse marking a completed roll.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 fallback  output  1  high when either die of the current roll was forced by the fallback rule.

Function
REQ-014 The block SHALL implement states IDLE, ADV1, SMP1, ADV2, SMP2 and DONE, with one state per cycle except ADV1 and ADV2.
REQ-015 IDLE with roll_req=1 SHALL go to ADV1, clear the step and retry counters, and clear fallback; IDLE with roll_req=0 SHALL stay in IDLE.
REQ-016 ADV1 and ADV2 SHALL drive adv=1 for exactly STEPS consecutive cycles, then move to SMP1 or SMP2 respectively.
REQ-017 SMP1 and SMP2 SHALL drive adv=0 and evaluate the candidate c=rnd[2:0].
REQ-018 If c is in 1..6, the candidate SHALL be accepted: SMP1 loads die1 and goes to ADV2 with the retry counter cleared; SMP2 loads die2 and goes to DONE.
REQ-019 If c is 0 or 7 and the retry count is below MAX_TRY, the retry counter SHALL increment and the state SHALL return to ADV1 or ADV2 (the same die).
REQ-020 If c is 0 or 7 and the retry count equals MAX_TRY, the die SHALL be forced (0 becomes 1, 7 becomes 6), fallback SHALL be set, and the state SHALL advance as on acceptance.
REQ-021 sum SHALL be registered as the zero-extended die1+die2 on the SMP2-to-DONE transition.
REQ-022 DONE SHALL assert valid for one cycle, then return to IDLE unconditionally; roll_req during DONE SHALL be ignored.
REQ-023 roll_req while busy=1 SHALL be ignored, with no queuing.
REQ-024 die1, die2, sum and fallback SHALL hold their last values in IDLE until the next SMP1 or SMP2 load.
REQ-025 Latency: with roll_req sampled at edge N and no rejections, valid SHALL be high in the cycle after edge N+2*(STEPS+1); each rejection SHALL add STEPS+1 cycles.
REQ-026 adv SHALL be a registered output, with no combinational path from rnd or roll_req.

Reset
REQ-027 rst=1 at a rising edge SHALL force state IDLE, adv=0, valid=0, busy=0, fallback=0, die1=0, die2=0, sum=0, and all counters to 0.
REQ-028 rst SHALL take priority over every transition, including mid-roll; an aborted roll SHALL produce no valid pulse and adv=0 from the next cycle.

Verification
REQ-029 Reset: assert rst for 2 cycles -> all outputs 0, busy=0.
REQ-030 rnd held at 6'b000011, roll_req pulse at edge N -> exactly 6 adv cycles, valid at edge N+8, die1=3, die2=3, sum=6, fallback=0.
REQ-031 rnd[2:0] is 7 at the first SMP1, 5 at the second SMP1, and 2 at SMP2 -> die1=5, die2=2, sum=7, valid at edge N+12, 9 adv cycles.
REQ-032 rnd held at 0 -> each die forced after 16 samples, die1=1, die2=1, sum=2, fallback=1, valid at edge N+128.
REQ-033 roll_req held high continuously -> back-to-back rolls separated by exactly one IDLE cycle; a roll_req pulse mid-roll is ignored.
REQ-034 rst asserted during ADV2 -> adv=0 and busy=0 the next cycle, no valid pulse, all outputs 0.

Source files
------------

// File: rtl/dice_if.sv
// Bus bundle between a roll requester / generator and the dice sampler.
interface dice_if;
    logic       roll_req;
    logic [5:0] rnd;
    logic       adv;
    logic [2:0] die1;
    logic [2:0] die2;
    logic [3:0] sum;
    logic       valid;
    logic       busy;
    logic       fallback;

    modport master (
        output roll_req, rnd,
        input  adv, die1, die2, sum, valid, busy, fallback
    );

    modport slave (
        input  roll_req, rnd,
        output adv, die1, die2, sum, valid, busy, fallback
    );
endinterface

// File: rtl/dice_sampler.sv
// Rolls two dice by rejection-sampling rnd[2:0] from an external shift-register
// generator, advancing the generator STEPS times before each sample.
module dice_sampler #(
    parameter int unsigned STEPS   = 3,
    parameter int unsigned MAX_TRY = 15
) (
    input  logic  clock,
    input  logic  rst,
    dice_if.slave bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADV1 = 3'd1;
    localparam logic [2:0] S_SMP1 = 3'd2;
    localparam logic [2:0] S_ADV2 = 3'd3;
    localparam logic [2:0] S_SMP2 = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [2:0] STEP_LAST = 3'(STEPS - 1);
    localparam logic [3:0] TRY_LAST  = 4'(MAX_TRY);

    logic [2:0] state_q, state_d;
    logic [2:0] step_q, step_d;
    logic [3:0] try_q, try_d;
    logic       adv_q, adv_d;
    logic [2:0] die1_q, die1_d;
    logic [2:0] die2_q, die2_d;
    logic [3:0] sum_q, sum_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       fallback_q, fallback_d;

    logic [2:0] cand;
    logic       cand_ok;
    logic [2:0] pick;
    logic       take;

    // Candidate classification: 0 and 7 are rejects, forced to 1 and 6 on fallback.
    always_comb begin
        cand    = bus.rnd[2:0];
        cand_ok = (cand != 3'd0) && (cand != 3'd7);
        if (cand_ok) begin
            pick = cand;
        end else if (cand == 3'd0) begin
            pick = 3'd1;
        end else begin
            pick = 3'd6;
        end
        take = cand_ok || (try_q == TRY_LAST);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        try_d      = try_q;
        die1_d     = die1_q;
        die2_d     = die2_q;
        sum_d      = sum_q;
        fallback_d = fallback_q;
        valid_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.roll_req) begin
                    state_d    = S_ADV1;
                    step_d     = 3'd0;
                    try_d      = 4'd0;
                    fallback_d = 1'b0;
                end
            end
            S_ADV1, S_ADV2: begin
                if (step_q == STEP_LAST) begin
                    step_d  = 3'd0;
                    state_d = (state_q == S_ADV1) ? S_SMP1 : S_SMP2;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            S_SMP1: begin
                if (take) begin
                    die1_d     = pick;
                    fallback_d = fallback_q | ~cand_ok;
                    try_d      = 4'd0;
                    state_d    = S_ADV2;
                end else begin
                    try_d   = try_q + 4'd1;
                    state_d = S_ADV1;
                end
            end
            S_SMP2: begin
                if (take) begin
                    die2_d     = pick;
                    sum_d      = 4'(die1_q) + 4'(pick);
                    fallback_d = fallback_q | ~cand_ok;
                    valid_d    = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    try_d   = try_q + 4'd1;
                    state_d = S_ADV2;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        adv_d  = (state_d == S_ADV1) || (state_d == S_ADV2);
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; synchronous reset wins over any transition.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= S_IDLE;
            step_q     <= 3'd0;
            try_q      <= 4'd0;
            adv_q      <= 1'b0;
            die1_q     <= 3'd0;
            die2_q     <= 3'd0;
            sum_q      <= 4'd0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            fallback_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            try_q      <= try_d;
            adv_q      <= adv_d;
            die1_q     <= die1_d;
            die2_q     <= die2_d;
            sum_q      <= sum_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            fallback_q <= fallback_d;
        end
    end

    assign bus.adv      = adv_q;
    assign bus.die1     = die1_q;
    assign bus.die2     = die2_q;
    assign bus.sum      = sum_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
    assign bus.fallback = fallback_q;

endmodule

// File: tb/tb_dice_sampler.sv
// Directed bench for dice_sampler with STEPS=3, MAX_TRY=15.
module tb_dice_sampler;

    logic clock;
    logic rst;
    int   checks;
    int   errors;
    int   adv_cnt;

    dice_if dif ();

    dice_sampler #(.STEPS(3), .MAX_TRY(15)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (dif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock; tally adv as seen by the generator at that edge.
    task automatic step();
        if (dif.adv === 1'b1) adv_cnt++;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One roll: rnd starts at r0, becomes r1 after t1 edges and r2 after t2 edges.
    task automatic run_roll(input logic [5:0] r0, input logic [5:0] r1, input logic [5:0] r2,
                            input int t1, input int t2, input bit pulse_mid,
                            output int lat, output int advs);
        dif.rnd      = r0;
        adv_cnt      = 0;
        dif.roll_req = 1'b1;
        step();
        dif.roll_req = 1'b0;
        lat = 0;
        while (dif.valid !== 1'b1 && lat < 400) begin
            if (lat == t1) dif.rnd = r1;
            if (lat == t2) dif.rnd = r2;
            dif.roll_req = (pulse_mid && lat == 2);
            step();
            lat++;
        end
        dif.roll_req = 1'b0;
        advs = adv_cnt;
    endtask

    initial begin
        int lat;
        int advs;
        int cnt;
        int idle;
        int seen;

        checks       = 0;
        errors       = 0;
        adv_cnt      = 0;
        rst          = 1'b1;
        dif.roll_req = 1'b0;
        dif.rnd      = 6'd0;

        // Reset for two cycles.
        step();
        step();
        check("rst_adv", int'(dif.adv), 0);
        check("rst_busy", int'(dif.busy), 0);
        check("rst_valid", int'(dif.valid), 0);
        check("rst_die1", int'(dif.die1), 0);
        check("rst_die2", int'(dif.die2), 0);
        check("rst_sum", int'(dif.sum), 0);
        check("rst_fallback", int'(dif.fallback), 0);
        rst = 1'b0;
        step();

        // rnd stuck at 0: both dice forced to 1 after 16 samples each.
        run_roll(6'd0, 6'd0, 6'd0, -1, -1, 1'b0, lat, advs);
        check("zero_lat", lat, 128);
        check("zero_advs", advs, 96);
        check("zero_die1", int'(dif.die1), 1);
        check("zero_die2", int'(dif.die2), 1);
        check("zero_sum", int'(dif.sum), 2);
        check("zero_fallback", int'(dif.fallback), 1);
        check("done_busy", int'(dif.busy), 1);
        step();
        check("valid_one_cycle", int'(dif.valid), 0);
        check("idle_busy", int'(dif.busy), 0);
        step();
        step();
        check("hold_die1", int'(dif.die1), 1);
        check("hold_sum", int'(dif.sum), 2);
        check("hold_fallback", int'(dif.fallback), 1);

        // rnd stuck at 7: both dice forced to 6.
        run_roll(6'd7, 6'd7, 6'd7, -1, -1, 1'b0, lat, advs);
        check("seven_lat", lat, 128);
        check("seven_sum", int'(dif.sum), 12);
        check("seven_fallback", int'(dif.fallback), 1);
        step();

        // Constant 6'b000011: immediate accept, fallback cleared by the new roll.
        run_roll(6'b000011, 6'b000011, 6'b000011, -1, -1, 1'b0, lat, advs);
        check("three_lat", lat, 8);
        check("three_advs", advs, 6);
        check("three_die1", int'(dif.die1), 3);
        check("three_die2", int'(dif.die2), 3);
        check("three_sum", int'(dif.sum), 6);
        check("three_fallback", int'(dif.fallback), 0);
        step();

        // One rejection on die1 (7), then 5 and 2; upper rnd bits ignored.
        run_roll(6'b101111, 6'b110101, 6'b011010, 4, 8, 1'b0, lat, advs);
        check("rej_lat", lat, 12);
        check("rej_advs", advs, 9);
        check("rej_die1", int'(dif.die1), 5);
        check("rej_die2", int'(dif.die2), 2);
        check("rej_sum", int'(dif.sum), 7);
        check("rej_fallback", int'(dif.fallback), 0);
        step();

        // roll_req pulse mid-roll is neither honoured nor queued.
        run_roll(6'd4, 6'd4, 6'd4, -1, -1, 1'b1, lat, advs);
        check("mid_lat", lat, 8);
        check("mid_sum", int'(dif.sum), 8);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (dif.busy === 1'b1) seen++;
        end
        check("mid_no_queue", seen, 0);

        // roll_req held high: back-to-back rolls with one IDLE cycle between.
        dif.rnd      = 6'd3;
        dif.roll_req = 1'b1;
        cnt = 0;
        while (dif.valid !== 1'b1 && cnt < 100) begin
            step();
            cnt++;
        end
        check("b2b_first", int'(dif.valid), 1);
        cnt  = 0;
        idle = 0;
        step();
        cnt++;
        if (dif.busy === 1'b0) idle++;
        while (dif.valid !== 1'b1 && cnt < 100) begin
            step();
            cnt++;
            if (dif.busy === 1'b0) idle++;
        end
        check("b2b_gap", cnt, 10);
        check("b2b_idle", idle, 1);
        dif.roll_req = 1'b0;
        step();
        step();
        check("b2b_stop", int'(dif.busy), 0);

        // Reset during ADV2 aborts the roll.
        dif.rnd      = 6'd3;
        dif.roll_req = 1'b1;
        step();
        dif.roll_req = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("abort_pre_adv", int'(dif.adv), 1);
        check("abort_pre_die1", int'(dif.die1), 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_adv", int'(dif.adv), 0);
        check("abort_busy", int'(dif.busy), 0);
        check("abort_die1", int'(dif.die1), 0);
        check("abort_sum", int'(dif.sum), 0);
        check("abort_fallback", int'(dif.fallback), 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (dif.valid === 1'b1 || dif.busy === 1'b1) seen++;
        end
        check("abort_no_valid", seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
